// File: rtl/program_loader.sv
// program_loader: boot-time image loader for the single-cycle ARM-style core.
// A valid/ready byte stream carries a one-byte word count N followed by
// N big-endian instruction words. Each assembled word is written to
// instruction memory in order, and the core is held in reset until the last
// word has been committed.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start             one-cycle pulse that (re)starts a load session
//   byte_in/valid     image byte stream; byte_ready is the back-pressure
//   imem_we/addr/wdata instruction memory write port
//   cpu_rst           active-high reset to the processor
//   load_done         image complete, processor released
//   load_error        session aborted (bad header or inter-byte timeout)
//   words_loaded      words committed in the current session
module program_loader #(
  parameter int unsigned word_size           = 32,
  parameter int unsigned instruct_mem_length = 64,
  parameter int unsigned timeout_cycles      = 1000
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [7:0]                             byte_in,
  input  logic                                   byte_valid,
  output logic                                   byte_ready,
  output logic                                   imem_we,
  output logic [$clog2(instruct_mem_length)-1:0] imem_addr,
  output logic [word_size-1:0]                   imem_wdata,
  output logic                                   cpu_rst,
  output logic                                   load_done,
  output logic                                   load_error,
  output logic [$clog2(instruct_mem_length):0]   words_loaded
);

  localparam int unsigned AW  = $clog2(instruct_mem_length);
  localparam int unsigned WLW = AW + 1;
  localparam int unsigned BPW = word_size / 8;
  localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned ICW = $clog2(timeout_cycles + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HEADER  = 3'd1;
  localparam logic [2:0] S_COLLECT = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [AW-1:0]        last_q, last_d;     // index of the final word (N-1)
  logic [AW-1:0]        widx_q, widx_d;
  logic [BCW-1:0]       bcnt_q, bcnt_d;
  logic [ICW-1:0]       idle_q, idle_d;
  logic [word_size-1:0] asm_q, asm_d;
  logic [WLW-1:0]       wl_q, wl_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 cpu_rst_q, cpu_rst_d;

  logic accept;
  logic hdr_ok;

  assign byte_ready = (state_q == S_HEADER) || (state_q == S_COLLECT);
  assign accept     = byte_valid && byte_ready;
  assign hdr_ok     = (byte_in != 8'd0) && ({24'd0, byte_in} <= instruct_mem_length);

  // start in the WRITE cycle cancels that cycle's write.
  assign imem_we      = (state_q == S_WRITE) && !start;
  assign imem_addr    = widx_q;
  assign imem_wdata   = asm_q;
  assign cpu_rst      = cpu_rst_q;
  assign load_done    = done_q;
  assign load_error   = err_q;
  assign words_loaded = wl_q;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    widx_d    = widx_q;
    bcnt_d    = bcnt_q;
    idle_d    = idle_q;
    asm_d     = asm_q;
    wl_d      = wl_q;
    done_d    = done_q;
    err_d     = err_q;
    cpu_rst_d = cpu_rst_q;

    if (start) begin
      // start overrides everything, including a coincident byte handshake.
      state_d   = S_HEADER;
      widx_d    = '0;
      bcnt_d    = '0;
      idle_d    = '0;
      wl_d      = '0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      cpu_rst_d = 1'b1;
    end else begin
      case (state_q)
        S_HEADER: begin
          if (accept) begin
            if (hdr_ok) begin
              last_d  = AW'(byte_in - 8'd1);
              widx_d  = '0;
              bcnt_d  = '0;
              idle_d  = '0;
              state_d = S_COLLECT;
            end else begin
              err_d   = 1'b1;
              state_d = S_ERROR;
            end
          end
        end
        S_COLLECT: begin
          if (accept) begin
            asm_d  = (asm_q << 8) | word_size'(byte_in);
            idle_d = '0;
            if (bcnt_q == BCW'(BPW - 1)) begin
              bcnt_d  = '0;
              state_d = S_WRITE;
            end else begin
              bcnt_d = bcnt_q + BCW'(1);
            end
          end else if (idle_q == ICW'(timeout_cycles - 1)) begin
            err_d   = 1'b1;
            state_d = S_ERROR;
          end else begin
            idle_d = idle_q + ICW'(1);
          end
        end
        S_WRITE: begin
          wl_d   = wl_q + WLW'(1);
          idle_d = '0;
          if (widx_q == last_q) begin
            state_d = S_DONE;
          end else begin
            widx_d  = widx_q + AW'(1);
            state_d = S_COLLECT;
          end
        end
        S_DONE: begin
          // Registered from the state so the release lands one edge after
          // DONE is entered (two edges after the last byte).
          done_d    = 1'b1;
          cpu_rst_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      last_q    <= '0;
      widx_q    <= '0;
      bcnt_q    <= '0;
      idle_q    <= '0;
      asm_q     <= '0;
      wl_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      widx_q    <= widx_d;
      bcnt_q    <= bcnt_d;
      idle_q    <= idle_d;
      asm_q     <= asm_d;
      wl_q      <= wl_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes the expected memory
// writes, a negedge monitor pops and compares on every imem_we.
module tb_program_loader;

  localparam int unsigned WS  = 32;
  localparam int unsigned LEN = 64;
  localparam int unsigned TO  = 1000;
  localparam int unsigned AW  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [WS-1:0] imem_wdata;
  logic          cpu_rst;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   words_loaded;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [WS-1:0] data;
  } wr_t;

  wr_t exp_q[$];

  program_loader #(
    .word_size(WS),
    .instruct_mem_length(LEN),
    .timeout_cycles(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst),
    .load_done(load_done),
    .load_error(load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every memory write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b1 && imem_we === 1'b1) begin
      check("ready_low_in_write", 64'(byte_ready), 64'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h, no write expected", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 64'(imem_addr), 64'(e.addr));
        check("write_data", 64'(imem_wdata), 64'(e.data));
      end
    end
  end

  // Reference model: words i of a body are bytes 4i..4i+3, big-endian.
  task automatic expect_words(input logic [7:0] body[$], input int count);
    for (int i = 0; i < count; i++) begin
      exp_q.push_back(wr_t'{AW'(i), {body[4*i], body[4*i+1], body[4*i+2], body[4*i+3]}});
    end
  endtask

  task automatic send(input logic [7:0] b);
    bit ok = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (byte_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_wait: byte_ready 0 for 64 cycles, expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    byte_valid = 1'b0;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_we"}, 64'(imem_we), 64'd0);
    check({tag, "_addr"}, 64'(imem_addr), 64'd0);
    check({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd1);
    check({tag, "_done"}, 64'(load_done), 64'd0);
    check({tag, "_error"}, 64'(load_error), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  // Complete well-formed session from HEADER; checks the release latency.
  task automatic load_image(input logic [7:0] body[$], input int n, input int gap_max);
    expect_words(body, n);
    send(8'(n));
    for (int i = 0; i < 4 * n; i++) begin
      if (gap_max > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, gap_max));
      send(body[i]);
    end
    @(posedge clk);
    #1;
    check("done_not_yet", 64'(load_done), 64'd0);
    check("cpu_rst_held", 64'(cpu_rst), 64'd1);
    @(posedge clk);
    #1;
    check("load_done", 64'(load_done), 64'd1);
    check("cpu_released", 64'(cpu_rst), 64'd0);
    check("words_loaded", 64'(words_loaded), 64'(n));
    check("no_error", 64'(load_error), 64'd0);
  endtask

  task automatic bad_header(input logic [7:0] h);
    pulse_start();
    send(h);
    idle(2);
    check("bad_hdr_error", 64'(load_error), 64'd1);
    check("bad_hdr_cpu_rst", 64'(cpu_rst), 64'd1);
    check("bad_hdr_done", 64'(load_done), 64'd0);
    check("bad_hdr_ready", 64'(byte_ready), 64'd0);
  endtask

  initial begin
    logic [7:0] body[$];

    rst        = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    #12;
    check_reset_values("reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Happy path, byte_valid held high through the WRITE cycles.
    pulse_start();
    body = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load_image(body, 2, 0);

    // Bad headers: zero, one past depth, random oversize.
    bad_header(8'h00);
    bad_header(8'h41);
    bad_header(8'($urandom_range(66, 255)));

    // Timeout: exactly TO idle cycles after the last byte aborts.
    pulse_start();
    send(8'h01);
    send(8'h12);
    send(8'h34);
    idle(TO - 1);
    check("timeout_not_yet", 64'(load_error), 64'd0);
    idle(1);
    check("timeout_error", 64'(load_error), 64'd1);
    check("timeout_words", 64'(words_loaded), 64'd0);
    check("timeout_cpu_rst", 64'(cpu_rst), 64'd1);

    // Control: TO-1 idle cycles then the rest of the word completes.
    pulse_start();
    body = '{8'h12, 8'h34, 8'h56, 8'h78};
    expect_words(body, 1);
    send(8'h01);
    send(8'h12);
    send(8'h34);
    idle(TO - 1);
    send(8'h56);
    send(8'h78);
    idle(2);
    check("control_done", 64'(load_done), 64'd1);
    check("control_error", 64'(load_error), 64'd0);

    // start during the WRITE of the third of five words.
    pulse_start();
    body.delete();
    for (int i = 0; i < 20; i++) body.push_back(8'($urandom));
    expect_words(body, 2);
    send(8'h05);
    for (int i = 0; i < 12; i++) send(body[i]);
    check("restart_words_before", 64'(words_loaded), 64'd2);
    byte_valid = 1'b0;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("restart_words", 64'(words_loaded), 64'd0);
    check("restart_header_ready", 64'(byte_ready), 64'd1);
    check("restart_cpu_rst", 64'(cpu_rst), 64'd1);
    check("restart_done", 64'(load_done), 64'd0);
    body.delete();
    for (int i = 0; i < 12; i++) body.push_back(8'($urandom));
    load_image(body, 3, 0);

    // Asynchronous reset mid-COLLECT.
    pulse_start();
    body.delete();
    for (int i = 0; i < 12; i++) body.push_back(8'($urandom));
    expect_words(body, 1);
    send(8'h03);
    for (int i = 0; i < 6; i++) send(body[i]);
    #3 rst = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk) rst = 1'b1;
    byte_valid = 1'b0;
    @(posedge clk);
    #1;

    // Full depth.
    pulse_start();
    body.delete();
    for (int i = 0; i < 4 * LEN; i++) body.push_back(8'($urandom));
    load_image(body, LEN, 0);

    // Random sessions with random inter-byte gaps.
    for (int s = 0; s < 6; s++) begin
      int n;
      n = $urandom_range(1, 8);
      pulse_start();
      body.delete();
      for (int i = 0; i < 4 * n; i++) body.push_back(8'($urandom));
      load_image(body, n, 4);
    end

    idle(3);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
